// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the single register-file write port.
// Pipeline results take priority; long-latency results queue in a small FIFO
// and are forced through after STARVE_LIMIT consecutive losses. A busy
// scoreboard tracks registers with outstanding long-latency writes.
// Optional feature macro: REGFILE_WB_BYPASS_EN (direct write of an lu result
// when the FIFO is empty and the pipeline is not using the port).
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pipe_wb_valid,
    output logic                     pipe_wb_ready,
    input  logic [ADDR_W-1:0]        pipe_wb_addr,
    input  logic [DATA_W-1:0]        pipe_wb_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_addr,
    input  logic [DATA_W-1:0]        lu_data,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     reg_wr_en,
    output logic [ADDR_W-1:0]        write_address,
    output logic [DATA_W-1:0]        write_data
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic fifo_empty;
    logic force_fifo;
    logic pipe_acc;
    logic fifo_win;
    logic lu_acc;
    logic push;
    logic bypass;

    // Grant and handshake decode from current state.
    assign fifo_empty    = (count_q == '0);
    assign lu_ready      = (count_q != CNT_FULL);
    assign force_fifo    = (starve_q == STV_MAX) && !fifo_empty;
    assign pipe_wb_ready = !force_fifo;
    assign pipe_acc      = pipe_wb_valid && pipe_wb_ready;
    assign fifo_win      = !fifo_empty && !pipe_acc;
    assign lu_acc        = lu_valid && lu_ready;

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = fifo_empty && !pipe_acc && lu_acc && (lu_addr != '0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results are accepted but never stored.
    assign push = lu_acc && (lu_addr != '0) && !bypass;

    // FIFO storage, pointers and occupancy.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = lu_addr;
            fifo_data_d[wr_ptr_q] = lu_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (fifo_win) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(fifo_win);
    end

    // Starvation counter: counts consecutive pipeline wins over a waiting head.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_win) begin
            starve_d = '0;
        end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Busy scoreboard: clear on grant, set on reserve (set wins), x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_win) begin
            busy_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
        end
        if (bypass) begin
            busy_d[lu_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-port mux; address/data hold when idle.
    always_comb begin
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_acc) begin
            if (pipe_wb_addr != '0) begin
                wr_en_d = 1'b1;
                waddr_d = pipe_wb_addr;
                wdata_d = pipe_wb_data;
            end
        end else if (fifo_win) begin
            wr_en_d = 1'b1;
            waddr_d = fifo_addr_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            wr_en_d = 1'b1;
            waddr_d = lu_addr;
            wdata_d = lu_data;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
            wr_en_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign reg_wr_en     = wr_en_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;

endmodule
